// File: rtl/lock_arbiter_rr_if.sv
// lock_arbiter_rr_if: request/grant bundle between two cores and the lock arbiter
interface lock_arbiter_rr_if #(
    parameter int CNT_W = 8
);
    logic             req_1;
    logic             req_2;
    logic             grant_1;
    logic             grant_2;
    logic             owner;
    logic             busy;
    logic             revoke;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req_1, req_2,
        input  grant_1, grant_2, owner, busy, revoke, hold_cnt
    );

    modport slave (
        input  req_1, req_2,
        output grant_1, grant_2, owner, busy, revoke, hold_cnt
    );
endinterface

// File: rtl/lock_arbiter_rr.sv
// lock_arbiter_rr: two-core round-robin memory lock; define LOCK_TIMEOUT_EN for forced revocation of contested locks
module lock_arbiter_rr #(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    lock_arbiter_rr_if.slave bus
);
`ifdef LOCK_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GNT1, GNT2, GAP} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic             r_blk_1, r_blk_2;
    logic             r_grant_1, r_grant_2, r_owner, r_busy, r_revoke;
    logic             w_elig_1, w_elig_2, w_at_limit, w_revoke;

    // a revoked core stays ineligible until its request has been seen low
    assign w_elig_1   = bus.req_1 && !r_blk_1;
    assign w_elig_2   = bus.req_2 && !r_blk_2;
    assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 1'b1;
    // the limit is reached once this grant cycle brings the held count to MAX_HOLD
    assign w_at_limit = w_cnt_inc == CNT_W'(MAX_HOLD);

    // next state: round-robin pick in IDLE, release or revocation while granted
    always_comb begin
        w_next   = r_state;
        w_revoke = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig_1 && w_elig_2) w_next = r_owner ? GNT1 : GNT2;
                else if (w_elig_1)        w_next = GNT1;
                else if (w_elig_2)        w_next = GNT2;
            end
            GNT1: begin
                if (!bus.req_1) w_next = GAP;
                else if (TIMEOUT && w_at_limit && w_elig_2) begin
                    w_next   = GAP;
                    w_revoke = 1'b1;
                end
            end
            GNT2: begin
                if (!bus.req_2) w_next = GAP;
                else if (TIMEOUT && w_at_limit && w_elig_1) begin
                    w_next   = GAP;
                    w_revoke = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // state, registered outputs, hold counter and revoke-block flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_grant_1 <= 1'b0;
            r_grant_2 <= 1'b0;
            r_owner   <= 1'b1;
            r_busy    <= 1'b0;
            r_revoke  <= 1'b0;
            r_cnt     <= '0;
            r_blk_1   <= 1'b0;
            r_blk_2   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_grant_1 <= w_next == GNT1;
            r_grant_2 <= w_next == GNT2;
            r_busy    <= w_next != IDLE;
            r_revoke  <= w_revoke;
            r_blk_1   <= (r_blk_1 && bus.req_1) || (w_revoke && r_state == GNT1);
            r_blk_2   <= (r_blk_2 && bus.req_2) || (w_revoke && r_state == GNT2);
            if (r_state == IDLE && w_next != IDLE) begin
                r_owner <= w_next == GNT2;
                r_cnt   <= '0;
            end else if (r_state == GNT1 || r_state == GNT2) begin
                r_cnt   <= w_cnt_inc;
            end
        end
    end

    assign bus.grant_1  = r_grant_1;
    assign bus.grant_2  = r_grant_2;
    assign bus.owner    = r_owner;
    assign bus.busy     = r_busy;
    assign bus.revoke   = r_revoke;
    assign bus.hold_cnt = r_cnt;
endmodule

// File: doc/lock_arbiter_rr.md
LOCK_ARBITER_RR -- requirements
Module: lock_arbiter_rr

Interface
REQ-001 Parameter MAX_HOLD, default 64: grant cycles allowed before a contested lock is revoked (range 2-255).
REQ-002 Parameter CNT_W, default 8: hold-counter width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_1  input  1  core 1 lock request, level, held while lock is wanted.
REQ-006 req_2  input  1  core 2 lock request, level.
REQ-007 grant_1  output  1  core 1 owns memory lock.
REQ-008 grant_2  output  1  core 2 owns memory lock.
REQ-009 owner  output  1  last/current owner: 0 = core 1, 1 = core 2.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 revoke  output  1  one-cycle pulse when a lock is forcibly revoked.

Function
REQ-012 The block SHALL implement states IDLE, GNT1, GNT2 and GAP; all outputs registered.
REQ-013 grant_1 and grant_2 SHALL never be high in the same cycle.
REQ-014 IDLE: single request sampled at edge N SHALL assert the matching grant from edge N (visible after edge N); latency one cycle from request.
REQ-015 IDLE with req_1 and req_2 both high: grant SHALL go to the core not equal to owner (round-robin).
REQ-016 GNTx: grant held while reqx high; reqx low at edge N SHALL drop grant at edge N and enter GAP.
REQ-017 GAP SHALL last exactly one cycle with no grant, then return to IDLE; requests are re-evaluated in IDLE on the following edge.
REQ-018 owner SHALL update on the edge a grant is asserted and hold its value otherwise.
REQ-019 Hold counter SHALL clear on grant assertion, increment each GNTx cycle, saturate at 2^CNT_W-1.
REQ-020 Requests changing during GAP SHALL be ignored until IDLE.
REQ-021 A core whose lock was revoked SHALL not be re-granted until its request has been observed low for at least one edge.

Reset
REQ-022 On rst low: state IDLE, grant_1=0, grant_2=0, owner=1 (so core 1 wins first contest), busy=0, revoke=0, counter=0, revoke-block flags cleared.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), not at the next edge.
REQ-024 First rising edge after rst deasserts SHALL evaluate requests normally.

Configuration
REQ-025 Macro LOCK_TIMEOUT_EN SHALL control forced revocation.
REQ-026 With LOCK_TIMEOUT_EN defined: in GNTx, when counter equals MAX_HOLD and the other core requests, grant SHALL drop, revoke pulses one cycle, state enters GAP, revoke-block set for that core.
REQ-027 Without LOCK_TIMEOUT_EN: no revocation; revoke tied 0; REQ-021 inactive; lock held until owner releases.

Verification
REQ-028 Reset release, req_1=1 at edge 1 -> grant_1=1 after edge 1, owner=0, busy=1; req_1=0 at edge 5 -> grant_1=0, one GAP cycle, busy=0 after edge 6.
REQ-029 From reset, req_1=req_2=1 same edge -> grant_1 first; core 1 releases -> after GAP grant_2=1, owner=1; repeat contest -> grant_1.
REQ-030 req_2 rises while grant_1 held -> grant_2 stays 0 until grant_1 drops plus one GAP cycle; never both high.
REQ-031 LOCK_TIMEOUT_EN, MAX_HOLD=4, core 1 holds with req_2=1 -> grant_1 drops after 4 grant cycles, revoke=1 for one cycle, grant_2 follows after GAP; core 1 re-requesting without dropping req_1 is not granted.
REQ-032 Without LOCK_TIMEOUT_EN, same stimulus held 300 cycles -> grant_1 stays 1, revoke stays 0, counter saturated at 255.
REQ-033 rst pulled low mid-grant between edges -> grant outputs 0 before next edge; owner=1 after release.
